// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: owns the PC, runs the instruction-memory request/ready
// handshake and resolves branch redirects against hazard stalls for IF/ID.
module fetch_seq #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSrc_F,
    input  logic [N-1:0]  PCBranch_F,
    input  logic          stall_F,
    input  logic          imem_ready,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr_F,
    output logic          instr_valid_F,
    output logic          flush_D
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [N-1:0] PC_STEP    = N'(4);
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

    state_t        state;
    logic [N-1:0]  pc;
    logic          pend;
    logic [N-1:0]  pend_tgt;

    logic          redir;
    logic [N-1:0]  branch_tgt;
    logic [N-1:0]  tgt;
    logic [N-1:0]  pc_plus4;

    // Targets are word aligned; a live redirect always beats one parked during a wait.
    assign branch_tgt  = PCBranch_F & ALIGN_MASK;
    assign redir       = PCSrc_F | pend;
    assign tgt         = PCSrc_F ? branch_tgt : pend_tgt;
    assign pc_plus4    = pc + PC_STEP;
    assign imem_addr_F = pc;

    always_comb begin
        imem_req      = 1'b0;
        instr_valid_F = 1'b0;
        flush_D       = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (!imem_ready) begin
                        flush_D = PCSrc_F;
                    end else if (redir) begin
                        flush_D = 1'b1;
                    end else begin
                        instr_valid_F = 1'b1;
                    end
                end
                HOLD: begin
                    if (PCSrc_F) begin
                        flush_D = 1'b1;
                    end else begin
                        instr_valid_F = 1'b1;
                    end
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    // HOLD keeps the address steady so a combinational memory keeps presenting
    // the stalled instruction without issuing a new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            state    <= FETCH;
            pend     <= 1'b0;
            pend_tgt <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!imem_ready) begin
                        if (PCSrc_F) begin
                            pend     <= 1'b1;
                            pend_tgt <= branch_tgt;
                        end
                    end else if (redir) begin
                        pc   <= tgt;
                        pend <= 1'b0;
                    end else if (stall_F) begin
                        state <= HOLD;
                    end else begin
                        pc <= pc_plus4;
                    end
                end
                HOLD: begin
                    if (PCSrc_F) begin
                        pc    <= branch_tgt;
                        state <= FETCH;
                    end else if (!stall_F) begin
                        pc    <= pc_plus4;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: directed scenarios then random traffic,
// checked against a transaction-level model of the fetch rules.
module tb_fetch_seq;

    localparam int          N        = 64;
    localparam logic [63:0] RESET_PC = 64'd0;

    logic          clk;
    logic          reset;
    logic          PCSrc_F;
    logic [63:0]   PCBranch_F;
    logic          stall_F;
    logic          imem_ready;
    logic          imem_req;
    logic [63:0]   imem_addr_F;
    logic          instr_valid_F;
    logic          flush_D;

    fetch_seq #(.N(N), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (PCSrc_F),
        .PCBranch_F    (PCBranch_F),
        .stall_F       (stall_F),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .imem_addr_F   (imem_addr_F),
        .instr_valid_F (instr_valid_F),
        .flush_D       (flush_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        addr_known;
        logic        req;
        logic        valid;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Reference model: the PC, whether a fetched instruction is being held for
    // a stall, and a queue holding at most one redirect parked during a wait.
    logic [63:0] m_pc;
    logic        m_known;
    logic        m_holding;
    logic [63:0] m_pend[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        check_count++;
        if (act === req) begin
            pass_count++;
        end else begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
    task automatic applyStimulus(input logic rst, input logic src, input logic [63:0] target,
                                 input logic stall, input logic ready);
        exp_t        e;
        logic [63:0] aligned;
        reset      = rst;
        PCSrc_F    = src;
        PCBranch_F = target;
        stall_F    = stall;
        imem_ready = ready;
        aligned    = {target[63:2], 2'b00};
        e.addr       = m_pc;
        e.addr_known = m_known;
        e.req        = 1'b0;
        e.valid      = 1'b0;
        e.flush      = 1'b0;
        if (rst) begin
            m_pc      = RESET_PC;
            m_known   = 1'b1;
            m_holding = 1'b0;
            m_pend.delete();
        end else if (m_holding) begin
            if (src) begin
                e.flush   = 1'b1;
                m_pc      = aligned;
                m_holding = 1'b0;
            end else begin
                e.valid = 1'b1;
                if (!stall) begin
                    m_pc      = m_pc + 64'd4;
                    m_holding = 1'b0;
                end
            end
        end else begin
            e.req = 1'b1;
            if (!ready) begin
                e.flush = src;
                if (src) begin
                    m_pend.delete();
                    m_pend.push_back(aligned);
                end
            end else if (src || m_pend.size() > 0) begin
                e.flush = 1'b1;
                m_pc    = src ? aligned : m_pend[0];
                m_pend.delete();
            end else begin
                e.valid = 1'b1;
                if (stall) m_holding = 1'b1;
                else       m_pc = m_pc + 64'd4;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.addr_known) checkOutput("imem_addr_F", imem_addr_F, e.addr);
                checkOutput("imem_req", {63'd0, imem_req}, {63'd0, e.req});
                checkOutput("instr_valid_F", {63'd0, instr_valid_F}, {63'd0, e.valid});
                checkOutput("flush_D", {63'd0, flush_D}, {63'd0, e.flush});
            end
        end
    end

    initial begin
        logic [63:0] rtgt;
        int          wait_cycles;
        m_pc      = '0;
        m_known   = 1'b0;
        m_holding = 1'b0;
        reset      = 1'b1;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;
        stall_F    = 1'b0;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;

        // 50 ns reset, then free run
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // Redirect to an unaligned target
        applyStimulus(1'b0, 1'b1, 64'd4006, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // Stall for 3 cycles at PC = 40
        applyStimulus(1'b0, 1'b1, 64'd40, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // Memory wait at PC = 80 with a redirect parked in wait cycle 2
        applyStimulus(1'b0, 1'b1, 64'd80, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'd200, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // Redirect beats stall while holding
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 64'h100, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // Reset during a wait drops the parked redirect
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // PC wraps from 2^64-4 to 0
        applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 1'b1);

        // Random traffic, including targets close to the wrap point
        for (int i = 0; i < 1500; i++) begin
            rtgt = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rtgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) == 0,
                          rtgt,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 3) != 0);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            check_count++;
            fail_count++;
            $display("[TB] FAIL drain: actual=%0d pending predictions required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch-stage sequencer for the pipelined LEGv8 core. It owns the program counter and drives the instruction-memory request/ready handshake, so fetch works with both zero-wait and multi-cycle instruction memories. It resolves branch redirects (`PCSrc_F`/`PCBranch_F`) against hazard-unit stalls and signals the IF/ID register when to capture or squash. It replaces the free-running PC+4 register inside `fetch` and keeps the same redirect ports.

## Interface
- `N` — default 64 — address/PC width.
- `RESET_PC` — default 0 — PC value loaded on reset.

Ports:
- `clk` — in — 1 — clock; all state updates on the rising edge.
- `reset` — in — 1 — synchronous, active-high reset.
- `PCSrc_F` — in — 1 — branch/jump redirect request from the execute/memory stage.
- `PCBranch_F` — in — N — redirect target; bits [1:0] are ignored and treated as 0.
- `stall_F` — in — 1 — hazard-unit stall; IF/ID must not advance.
- `imem_ready` — in — 1 — instruction memory has data for `imem_addr_F`; may be high in the same cycle as `imem_req`.
- `imem_req` — out — 1 — fetch request valid for `imem_addr_F`.
- `imem_addr_F` — out — N — current PC, driven directly from the PC register.
- `instr_valid_F` — out — 1 — instruction at `imem_addr_F` is valid for IF/ID capture this cycle.
- `flush_D` — out — 1 — squash the IF/ID contents this cycle (a redirect was taken).

## Operation
- State: `pc[N-1:0]`, `state ∈ {FETCH, HOLD}`, `pend` (1 bit), `pend_tgt[N-1:0]`.
- Define `redir = PCSrc_F | pend` and `tgt = PCSrc_F ? PCBranch_F : pend_tgt`. A live `PCSrc_F` beats a pending target.
- All targets are stored with bits [1:0] = 0.

FETCH state:
- `imem_req` = 1.
- While `imem_ready` = 0:
  - `pc` holds and `instr_valid_F` = 0.
  - If `PCSrc_F` = 1, set `pend` = 1 and `pend_tgt` = `PCBranch_F`. A later `PCSrc_F` overwrites the target.
  - `flush_D` = `PCSrc_F`.
- With `imem_ready` = 1 and `redir` = 1:
  - `instr_valid_F` = 0 and `flush_D` = 1.
  - `pc` ← `tgt`, `pend` ← 0, stay in FETCH.
- With `imem_ready` = 1, `redir` = 0 and `stall_F` = 1:
  - `instr_valid_F` = 1, `pc` holds, go to HOLD.
- With `imem_ready` = 1, `redir` = 0 and `stall_F` = 0:
  - `instr_valid_F` = 1, `pc` ← `pc + 4`, stay in FETCH.

HOLD state:
- `imem_req` = 0. `imem_addr_F` stays stable, so combinational memory output remains valid.
- `PCSrc_F` = 1: `instr_valid_F` = 0, `flush_D` = 1, `pc` ← `PCBranch_F`, go to FETCH.
- Else if `stall_F` = 0: `instr_valid_F` = 1, `pc` ← `pc + 4`, go to FETCH.
- Else: `instr_valid_F` = 1, hold.

Arithmetic:
- `pc + 4` is N-bit, modulo 2^N. From `2^N − 4` it wraps to 0 with no flag.

## Timing
- Reset (synchronous, checked at the rising edge):
  - Loads `pc` = `RESET_PC`, `state` = FETCH, `pend` = 0, `pend_tgt` = 0.
  - While `reset` = 1, `imem_req` = `instr_valid_F` = `flush_D` = 0, overriding state decoding.
- Reset overrides any operation in progress. A pending redirect or outstanding request is dropped. The memory must tolerate an abandoned request.
- `instr_valid_F`, `flush_D` and `imem_req` are combinational from state and inputs, with no registered latency. `imem_addr_F` is registered.
- Zero-wait memory (`imem_ready` tied 1), no stalls: `imem_addr_F` steps `RESET_PC`, +4, +8, … one per cycle, starting the first edge after reset deasserts.
- Redirect latency: `PCSrc_F` high in cycle t (memory ready, or in HOLD) puts `imem_addr_F` = target in cycle t+1.
- Redirect during a wait: it takes effect in the cycle after `imem_ready` is seen.
- Simultaneous events:
  - Redirect beats stall.
  - `imem_ready` with a redirect discards the returned instruction.
  - `PCSrc_F` in the same cycle as a `pend` hit uses the live `PCBranch_F`.
- Never: `instr_valid_F` and `flush_D` both 1 in the same cycle.
- Never: `pc` changes while in FETCH with `imem_ready` = 0.

## Test plan
- **Free run:** `imem_ready` = 1, `stall_F` = 0, `PCSrc_F` = 0, 50 ns reset at 10 ns clock period → `imem_addr_F` = 0 on the first cycle after reset; it then increments by exactly 4 each cycle for 100 cycles; `instr_valid_F` = 1 throughout.
- **Redirect:** after the free run, `PCSrc_F` = 1 with `PCBranch_F` = 4006 for one cycle → next-cycle `imem_addr_F` = 4004; `flush_D` = 1 only in the redirect cycle; the following cycle gives 4008.
- **Stall:** `stall_F` = 1 for 3 cycles at PC = 40 → `imem_addr_F` holds 40; `imem_req` = 0 during HOLD; `instr_valid_F` = 1; PC = 44 one cycle after `stall_F` falls.
- **Wait plus pending redirect:** `imem_ready` low for 4 cycles at PC = 80, with `PCSrc_F` pulsed (target 200) in wait cycle 2 → `flush_D` = 1 in that cycle; PC holds 80; when ready returns, `instr_valid_F` = 0; PC = 200 next cycle.
- **Priority:** `stall_F` = 1 and `PCSrc_F` = 1 (target 0x100) together in HOLD → PC = 0x100 next cycle; state returns to FETCH; `instr_valid_F` = 0 in that cycle.
- **Reset and wrap:**
  - Assert `reset` for one cycle during a memory wait with a pending redirect → PC = `RESET_PC`, pending target discarded.
  - Force PC = `2^64 − 4` via redirect with free run → next PC = 0.
